// File: rtl/datapath_pkg.sv
// datapath_pkg: shared encodings for datapath_muldiv.
// Holds funct codes, writeback/branch selects, iterator states and ops.
package datapath_pkg;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADDI = 6'h08;
    localparam logic [5:0] F_MUL  = 6'h18;
    localparam logic [5:0] F_DIVU = 6'h1B;
    localparam logic [5:0] F_REMU = 6'h1D;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [2:0] WB_ZERO = 3'd0;
    localparam logic [2:0] WB_ALU  = 3'd1;
    localparam logic [2:0] WB_DM   = 3'd2;
    localparam logic [2:0] WB_IN   = 3'd3;
    localparam logic [2:0] WB_IMM  = 3'd4;
    localparam logic [2:0] WB_HD   = 3'd5;
    localparam logic [2:0] WB_RD   = 3'd6;
    localparam logic [2:0] WB_PC   = 3'd7;

    localparam logic [1:0] BQ_EQ = 2'd1;
    localparam logic [1:0] BQ_NE = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [1:0] MD_MUL  = 2'd0;
    localparam logic [1:0] MD_DIVU = 2'd1;
    localparam logic [1:0] MD_REMU = 2'd2;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle MUL / DIVU / REMU engine.
// Ports: clk, rst, start/op/opa/opb in; idle, res_valid, result, div_zero out.
module muldiv_iter
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    output logic              idle,
    output logic              res_valid,
    output logic [DATA_W-1:0] result,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // acc: product (MUL) or partial remainder (DIV/REM)
    logic [DATA_W-1:0] acc_q, acc_d;
    // a: shifting multiplicand (MUL) or dividend/quotient (DIV/REM)
    logic [DATA_W-1:0] a_q, a_d;
    // b: shifting multiplier (MUL) or divisor (DIV/REM)
    logic [DATA_W-1:0] b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic              dz_q, dz_d;
    logic [DATA_W:0]   rem_sh;
    logic              rem_ge;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        dz_d    = dz_q;
        rem_sh  = {acc_q, a_q[DATA_W-1]};
        rem_ge  = rem_sh >= {1'b0, b_q};
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    acc_d = '0;
                    a_d   = opa;
                    b_d   = opb;
                    dz_d  = 1'b0;
                    state_d = ST_BUSY;
                    // Divide by zero skips iteration entirely.
                    if (op != MD_MUL && opb == '0) begin
                        dz_d    = 1'b1;
                        acc_d   = opa;
                        a_d     = '1;
                        state_d = ST_WB;
                    end
                end
            end
            ST_BUSY: begin
                if (op_q == MD_MUL) begin
                    if (b_q[0]) acc_d = acc_q + a_q;
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end else begin
                    acc_d = rem_ge ? DATA_W'(rem_sh - {1'b0, b_q})
                                   : rem_sh[DATA_W-1:0];
                    a_d = {a_q[DATA_W-2:0], rem_ge};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WB;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MD_MUL;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            dz_q    <= dz_d;
        end
    end

    assign idle      = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_WB);
    assign result    = (op_q == MD_DIVU) ? a_q : acc_q;
    assign div_zero  = res_valid & dz_q;

endmodule

// File: rtl/datapath_muldiv.sv
// datapath_muldiv: register file, ALU, branch compare, DM addressing,
// writeback mux and iterative mul/div; ready stalls control while busy.
module datapath_muldiv
    import datapath_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ADDR_W     = 12,
    parameter int ZERO_REG   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic              valid,
    output logic              ready,
    input  logic              flagRF,
    input  logic              flagAddrRF,
    input  logic              flagLSR,
    input  logic              flagJR,
    input  logic [1:0]        flagBQ,
    input  logic [2:0]        flagMuxRF,
    input  logic              flagMulDiv,
    input  logic [DATA_W-1:0] dataReadDM,
    input  logic [DATA_W-1:0] IN,
    input  logic [DATA_W-1:0] dataFromHD,
    input  logic [ADDR_W-1:0] processPC,
    output logic [5:0]        opcode,
    output logic [DATA_W-1:0] RDvalue,
    output logic [DATA_W-1:0] RSvalue,
    output logic [DATA_W-1:0] RTvalue,
    output logic [DATA_W-1:0] OUT,
    output logic [ADDR_W-1:0] addressDM,
    output logic [ADDR_W-1:0] newAddress,
    output logic              flagJB,
    output logic              done,
    output logic              divByZero
);

    localparam int NREG = 2 ** REG_ADDR_W;
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0]     rf_q [NREG];
    logic                  done_q, done_d;
    logic                  dbz_q, dbz_d;
    logic [REG_ADDR_W-1:0] md_addr_q, md_addr_d;
    logic                  md_wen_q, md_wen_d;

    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rd_a, rs_a, rt_a, dst_a;
    logic [SH_W-1:0]       shamt;
    logic [DATA_W-1:0]     imm_op_x, imm_ld_x, alu_y, wb_y;
    logic                  accept, accept_sc, accept_md;
    logic [1:0]            md_op;
    logic                  md_valid, md_dz;
    logic [DATA_W-1:0]     md_result;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;

    assign opcode   = instruction[31:26];
    assign funct    = instruction[5:0];
    assign rd_a     = REG_ADDR_W'(instruction[25:21]);
    assign rs_a     = REG_ADDR_W'(instruction[20:16]);
    assign rt_a     = REG_ADDR_W'(instruction[15:11]);
    assign imm_op_x = DATA_W'($signed(instruction[15:6]));
    assign imm_ld_x = DATA_W'($signed(instruction[20:0]));

    always_comb begin
        RDvalue = rf_q[rd_a];
        RSvalue = rf_q[rs_a];
        RTvalue = rf_q[rt_a];
        if (ZERO_REG != 0) begin
            if (rd_a == '0) RDvalue = '0;
            if (rs_a == '0) RSvalue = '0;
            if (rt_a == '0) RTvalue = '0;
        end
    end

    assign shamt = RTvalue[SH_W-1:0];

    always_comb begin
        alu_y = '0;
        case (funct)
            F_ADD:   alu_y = RSvalue + RTvalue;
            F_SUB:   alu_y = RSvalue - RTvalue;
            F_AND:   alu_y = RSvalue & RTvalue;
            F_OR:    alu_y = RSvalue | RTvalue;
            F_XOR:   alu_y = RSvalue ^ RTvalue;
            F_NOR:   alu_y = ~(RSvalue | RTvalue);
            F_SLT:   alu_y = {{(DATA_W-1){1'b0}},
                              $signed(RSvalue) < $signed(RTvalue)};
            F_SLL:   alu_y = RSvalue << shamt;
            F_SRL:   alu_y = RSvalue >> shamt;
            F_SRA:   alu_y = $signed(RSvalue) >>> shamt;
            F_ADDI:  alu_y = RSvalue + imm_op_x;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        wb_y = '0;
        case (flagMuxRF)
            WB_ALU:  wb_y = alu_y;
            WB_DM:   wb_y = dataReadDM;
            WB_IN:   wb_y = IN;
            WB_IMM:  wb_y = imm_ld_x;
            WB_HD:   wb_y = dataFromHD;
            WB_RD:   wb_y = RDvalue;
            WB_PC:   wb_y = DATA_W'(processPC);
            default: wb_y = '0;
        endcase
    end

    assign OUT        = (flagMuxRF == WB_IN) ? IN : RDvalue;
    assign addressDM  = flagLSR ? RSvalue[ADDR_W-1:0] : instruction[ADDR_W-1:0];
    assign newAddress = flagJR ? RDvalue[ADDR_W-1:0] : instruction[ADDR_W-1:0];
    assign flagJB     = (flagBQ == BQ_EQ) ? (RDvalue == RSvalue)
                      : (flagBQ == BQ_NE) ? (RDvalue != RSvalue) : 1'b0;

    assign accept    = valid & ready;
    assign accept_sc = accept & ~flagMulDiv;
    assign accept_md = accept & flagMulDiv;
    assign dst_a     = flagAddrRF ? RDvalue[REG_ADDR_W-1:0] : rd_a;

    always_comb begin
        md_op = MD_MUL;
        if (funct == F_DIVU) md_op = MD_DIVU;
        else if (funct == F_REMU) md_op = MD_REMU;
    end

    muldiv_iter #(
        .DATA_W(DATA_W)
    ) u_muldiv (
        .clk      (clock),
        .rst      (reset),
        .start    (accept_md),
        .op       (md_op),
        .opa      (RSvalue),
        .opb      (RTvalue),
        .idle     (ready),
        .res_valid(md_valid),
        .result   (md_result),
        .div_zero (md_dz)
    );

    always_comb begin
        done_d    = accept_sc | md_valid;
        dbz_d     = md_dz;
        md_addr_d = md_addr_q;
        md_wen_d  = md_wen_q;
        // Destination is frozen at acceptance; instruction may change later.
        if (accept_md) begin
            md_addr_d = dst_a;
            md_wen_d  = flagRF;
        end
        wr_en   = 1'b0;
        wr_addr = dst_a;
        wr_data = wb_y;
        if (md_valid) begin
            wr_en   = md_wen_q;
            wr_addr = md_addr_q;
            wr_data = md_result;
        end else if (accept_sc) begin
            wr_en = flagRF;
        end
        if (ZERO_REG != 0 && wr_addr == '0) wr_en = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            md_addr_q <= '0;
            md_wen_q  <= 1'b0;
        end else begin
            if (wr_en) rf_q[wr_addr] <= wr_data;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            md_addr_q <= md_addr_d;
            md_wen_q  <= md_wen_d;
        end
    end

    assign done      = done_q;
    assign divByZero = dbz_q;

endmodule

// File: doc/datapath_muldiv.md
# datapath_muldiv

Parametrised successor of the processor datapath: register file, single-cycle ALU, branch compare, data-memory addressing and writeback mux, plus an iterative multi-cycle multiply/divide unit behind a valid/ready handshake. It sits between the control unit (which supplies decoded flags) and the instruction/data memories. It stalls the control unit via `ready` while a long operation runs.

## Interface
- `DATA_W`, 32: register and datapath width (≥16).
- `REG_ADDR_W`, 5: register address width; `2**REG_ADDR_W` registers.
- `ADDR_W`, 12: instruction/data memory address width (≤21).
- `ZERO_REG`, 1: when 1, r0 reads 0 and writes to r0 are discarded.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instruction` in 32: opcode[31:26], RD[25:21], RS[20:16], RT[15:11], imm_op[15:6], funct[5:0], imm_load[20:0], target[ADDR_W-1:0].
- `valid` in 1: control presents an instruction.
- `ready` out 1: datapath accepts an instruction (IDLE only).
- `flagRF`, `flagAddrRF`, `flagLSR`, `flagJR` in 1 each: RF write enable; write address from RDvalue; DM address from RSvalue; jump-register target.
- `flagBQ` in 2: 1=BEQ, 2=BNE, else none.
- `flagMuxRF` in 3: writeback source: 1 ALU, 2 DM, 3 IN, 4 imm_load sign-extended, 5 HD, 6 RW readback, 7 processPC zero-extended, 0 zero.
- `flagMulDiv` in 1: funct selects a multi-cycle op.
- `dataReadDM`, `IN`, `dataFromHD` in DATA_W; `processPC` in ADDR_W.
- `opcode` out 6; `RDvalue`, `RSvalue`, `RTvalue`, `OUT` out DATA_W; `addressDM`, `newAddress` out ADDR_W; `flagJB` out 1.
- `done` out 1: one-cycle pulse, instruction committed.
- `divByZero` out 1: one-cycle pulse with `done` for DIV/REM by zero.

## Operation
- Reads combinational from `instruction` fields. `OUT` = IN if flagMuxRF==3, else RDvalue. `addressDM` = RSvalue or target per flagLSR. `newAddress` = RDvalue[ADDR_W-1:0] if flagJR, else target. `flagJB` per flagBQ compare of RDvalue and RSvalue.
- Single-cycle ALU (funct): ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLL/SRL/SRA (shift by RTvalue[log2 DATA_W-1:0]), ADDI (RS + sign-extended imm_op). Results wrap modulo 2^DATA_W.
- Multi-cycle ops (flagMulDiv=1): MUL (low DATA_W bits of unsigned product), DIVU, REMU. Shift-add / restoring algorithms, one bit per cycle.
- Divide by zero: quotient all-ones, remainder = dividend, `divByZero` pulses; no iteration.
- States: IDLE → (valid & flagMulDiv) → BUSY → (count == DATA_W-1) → WB → IDLE; divide-by-zero goes IDLE → WB directly.
- On acceptance of a multi-cycle op, latch operands, destination address and flagRF. Later changes on `instruction` do not affect the result.
- Writeback address is RD, or RDvalue[REG_ADDR_W-1:0] if flagAddrRF.

## Timing
- Single-cycle op: RF write at the accepting edge (valid & ready & !flagMulDiv). `done` is high the following cycle.
- MUL/DIV/REM: accepted at edge 0; BUSY for DATA_W cycles; RF write at edge DATA_W+1; `done` is high the cycle after; `ready` returns at the same time.
- `ready` is low in BUSY and WB. `valid` is ignored while `ready`=0.
- No read bypass: a read in the same cycle as a write returns the old value.
- Reset values: all registers 0, state IDLE, `ready`=1, `done`=0, `divByZero`=0, iteration counter 0.
- Reset mid-BUSY/WB: the operation is aborted with no RF write and no `done`.
- With ZERO_REG=1, a multi-cycle op targeting r0 still runs full latency and pulses `done`, but no write happens.

## Structure
- `datapath_pkg`: funct codes, flagMuxRF/flagBQ encodings, state enum.
- Sub-module `muldiv_iter`: start/busy/done handshake, operands, op select, result, div-by-zero flag.
- RF and ALU stay inline.

## Test plan
- Reset, then ADD r3=r1+r2 with r1=5, r2=7 → r3=12 at accepting edge, `done` next cycle, `ready` stays 1.
- MUL r4=r1*r2 with r1=0x10000, r2=0x10003 (DATA_W=32) → r4=0x00030000 written at edge 33, `ready` low for cycles 1–33.
- DIVU with 100/7 → 14; REMU → 2; DIVU 9/0 → 0xFFFFFFFF, `divByZero`=1, latency 2.
- Assert reset at cycle 10 of a MUL → no write, `ready`=1 next cycle, destination unchanged.
- ZERO_REG=1: write 0xDEAD to r0 → RDvalue of r0 reads 0. BEQ with r1==r2 → `flagJB`=1; `newAddress`=target.
- `valid` toggled during BUSY with a different ADD → ignored; result and destination match the latched MUL.
